// File: rtl/mfp_uart_tx_pkg.sv
// Shared UART constants and state encoding; the receiver is expected to reuse these.
package mfp_uart_tx_pkg;

    localparam int UART_DATA_W           = 8;
    localparam int UART_CLKS_PER_BIT_DEF = 434;

    typedef enum logic [1:0] {
        UART_STATE_IDLE  = 2'd0,
        UART_STATE_START = 2'd1,
        UART_STATE_DATA  = 2'd2,
        UART_STATE_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous transmit FIFO with registered full/empty flags derived from the next count.
module mfp_uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_empty_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_full, r_empty;
    logic          w_wr, w_pop;

    // Full is judged on the pre-edge count, so a simultaneous pop never rescues a write.
    assign w_wr  = i_wr && !r_full;
    assign w_pop = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata     = r_mem[r_rptr];
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_empty_nxt = (w_count_nxt == '0);

endmodule

// File: rtl/mfp_uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised LSB-first onto UART_TX.
module mfp_uart_tx
    import mfp_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                   SI_ClkIn,
    input  logic                   SI_Reset_N,
    input  logic                   tx_wr,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_full,
    output logic                   tx_empty,
    output logic                   tx_busy,
    output logic                   tx_ovf,
    input  logic                   tx_ovf_clr,
    output logic                   UART_TX
);

    localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_e            r_state, w_state_nxt;
    logic [BCW-1:0]         r_baud, w_baud_nxt;
    logic [2:0]             r_bit, w_bit_nxt;
    logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
    logic [UART_DATA_W-1:0] w_rdata;
    logic                   w_pop, w_full, w_empty, w_empty_nxt;
    logic                   w_baud_done, w_tx_nxt;
    logic                   r_tx, r_busy, r_ovf;

    mfp_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (UART_DATA_W)
    ) u_fifo (
        .i_clk       (SI_ClkIn),
        .i_rst_n     (SI_Reset_N),
        .i_wr        (tx_wr),
        .i_wdata     (tx_data),
        .i_pop       (w_pop),
        .o_rdata     (w_rdata),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_empty_nxt (w_empty_nxt)
    );

    assign w_baud_done = (r_baud == BCW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        if (r_state != UART_STATE_IDLE)
            w_baud_nxt = w_baud_done ? '0 : r_baud + BCW'(1);
        case (r_state)
            UART_STATE_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_rdata;
                    w_baud_nxt  = '0;
                    w_state_nxt = UART_STATE_START;
                end
            end
            UART_STATE_START: begin
                if (w_baud_done) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = UART_STATE_DATA;
                end
            end
            UART_STATE_DATA: begin
                if (w_baud_done) begin
                    w_shift_nxt = {1'b0, r_shift[UART_DATA_W-1:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = UART_STATE_STOP;
                end
            end
            UART_STATE_STOP: begin
                // Chain straight into the next start bit so back-to-back frames have no gap.
                if (w_baud_done) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_rdata;
                        w_state_nxt = UART_STATE_START;
                    end else begin
                        w_state_nxt = UART_STATE_IDLE;
                    end
                end
            end
            default: w_state_nxt = UART_STATE_IDLE;
        endcase
    end

    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            UART_STATE_START: w_tx_nxt = 1'b0;
            UART_STATE_DATA:  w_tx_nxt = r_shift[0];
            default:          w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            r_state <= UART_STATE_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= !w_empty_nxt || (w_state_nxt != UART_STATE_IDLE);
            if (tx_wr && w_full)
                r_ovf <= 1'b1;
            else if (tx_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign tx_full  = w_full;
    assign tx_empty = w_empty;
    assign tx_busy  = r_busy;
    assign tx_ovf   = r_ovf;
    assign UART_TX  = r_tx;

endmodule

// File: tb/tb_mfp_uart_tx.sv
// Bench for mfp_uart_tx: queue/timer reference model feeding a line-decoding scoreboard.
module tb_mfp_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int DCPB  = 434;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr, clr;
    logic [7:0] data;
    logic       tx_full, tx_empty, tx_busy, tx_ovf, line;
    logic       b_wr, b_clr;
    logic [7:0] b_data;
    logic       b_full, b_empty, b_busy, b_ovf, b_line;

    always #5 clk = ~clk;

    mfp_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
        .SI_ClkIn(clk), .SI_Reset_N(rst_n), .tx_wr(wr), .tx_data(data),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
        .tx_ovf(tx_ovf), .tx_ovf_clr(clr), .UART_TX(line)
    );

    mfp_uart_tx u_def (
        .SI_ClkIn(clk), .SI_Reset_N(rst_n), .tx_wr(b_wr), .tx_data(b_data),
        .tx_full(b_full), .tx_empty(b_empty), .tx_busy(b_busy),
        .tx_ovf(b_ovf), .tx_ovf_clr(b_clr), .UART_TX(b_line)
    );

    int          total = 0, bad = 0;
    int unsigned cyc = 0;
    logic [7:0]  mq[$];      // bytes waiting in the transmitter
    logic [7:0]  exp_q[$];   // bytes committed to the line, oldest first
    int          starts[$];  // cycle at which each observed frame began
    int          timer = 0;  // cycles left in the frame being sent
    bit          m_ovf = 0;
    bit          chk_on = 0;
    int          m_sz;
    bit          m_acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] frame_pat(input logic [7:0] b);
        logic [63:0] p;
        logic        v;
        p = '0;
        for (int k = 0; k < 10; k++) begin
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int j = 0; j < CPB; j++) p[k*CPB + j] = v;
        end
        return p;
    endfunction

    function automatic logic def_bit(input logic [7:0] b, input int k);
        return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
    endfunction

    always @(posedge clk) cyc++;

    // Reference: a frame occupies FRAME cycles; the next queued byte starts as one ends.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            timer = 0;
            m_ovf = 0;
        end else begin
            m_sz  = mq.size();
            m_acc = wr && (m_sz < DEPTH);
            if (timer <= 1 && m_sz > 0) begin
                exp_q.push_back(mq.pop_front());
                timer = FRAME;
            end else if (timer > 0) begin
                timer--;
            end
            if (m_acc) mq.push_back(data);
            if (wr && !m_acc) m_ovf = 1;
            else if (clr)     m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("tx_empty", tx_empty, mq.size() == 0);
            chk("tx_full",  tx_full,  mq.size() == DEPTH);
            chk("tx_busy",  tx_busy,  (mq.size() > 0) || (timer > 0));
            chk("tx_ovf",   tx_ovf,   m_ovf);
        end
    end

    bit          in_fr = 0;
    int          fpos;
    logic [63:0] samp;
    logic [7:0]  fexp;

    // Line decoder: captures every cycle of each frame and compares the whole waveform.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_fr = 0;
        end else begin
            if (!in_fr && line === 1'b0) begin
                in_fr = 1;
                fpos  = 0;
                samp  = '0;
                starts.push_back(cyc);
            end
            if (in_fr) begin
                samp[fpos] = line;
                fpos++;
                if (fpos == FRAME) begin
                    in_fr = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame: unexpected frame %h, none expected", samp);
                    end else begin
                        fexp = exp_q.pop_front();
                        chk("frame", samp, frame_pat(fexp));
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc && (tx_busy !== 1'b0 || in_fr); i++) @(negedge clk);
        if (i >= max_cyc) chk("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        wr   = 1'b1;
        data = b;
        @(negedge clk);
        wr   = 1'b0;
        data = $urandom;
    endtask

    int          n, sidx, t0;
    logic [7:0]  rb;

    initial begin
        rst_n = 1'b0; wr = 0; clr = 0; data = 0;
        b_wr = 0; b_clr = 0; b_data = 0;
        repeat (3) @(negedge clk);
        chk("rst_line",  line,     1);
        chk("rst_busy",  tx_busy,  0);
        chk("rst_full",  tx_full,  0);
        chk("rst_empty", tx_empty, 1);
        chk("rst_ovf",   tx_ovf,   0);
        chk("rst_bline", b_line,   1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_on = 1;

        // Single byte: start bit must appear two edges after the write edge.
        sidx = starts.size();
        n    = cyc + 1;
        put(8'hA5);
        wait_idle(200);
        chk("single_frames", starts.size() - sidx, 1);
        if (starts.size() > sidx) chk("single_latency", starts[sidx], n + 2);

        // Back-to-back: three frames with no idle cycle between them.
        sidx = starts.size();
        put(8'h00); put(8'hFF); put(8'h55);
        wait_idle(400);
        chk("b2b_frames", starts.size() - sidx, 3);
        if (starts.size() >= sidx + 3) begin
            chk("b2b_gap1", starts[sidx+1] - starts[sidx],   FRAME);
            chk("b2b_gap2", starts[sidx+2] - starts[sidx+1], FRAME);
        end
        chk("b2b_empty", tx_empty, 1);

        // Overflow: one in flight, DEPTH queued, the sixth dropped.
        for (int i = 0; i < 6; i++) put(8'($urandom));
        chk("ovf_set",  tx_ovf,  1);
        chk("ovf_full", tx_full, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovf_clr", tx_ovf, 0);

        // Write (with clear) landing on the STOP->START pop edge while full.
        for (int i = 0; i < 200 && timer != 1; i++) @(negedge clk);
        chk("pop_edge_found", timer, 1);
        wr = 1'b1; clr = 1'b1; data = 8'($urandom);
        @(negedge clk);
        wr = 1'b0; clr = 1'b0;
        chk("bnd_ovf",   tx_ovf,   1);
        chk("bnd_full",  tx_full,  0);
        chk("bnd_empty", tx_empty, 0);
        wait_idle(1000);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Reset during data bit 3 of a frame.
        sidx = starts.size();
        put(8'($urandom));
        for (int i = 0; i < 20 && starts.size() == sidx; i++) @(negedge clk);
        chk("rst_frame_started", starts.size() > sidx, 1);
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_line",  line,     1);
        chk("mid_busy",  tx_busy,  0);
        chk("mid_full",  tx_full,  0);
        chk("mid_empty", tx_empty, 1);
        chk("mid_ovf",   tx_ovf,   0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        sidx = starts.size();
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_quiet", line, 1);
        end
        chk("post_rst_noframe", starts.size(), sidx);
        put(8'h3C);
        wait_idle(200);
        chk("post_rst_frame", starts.size() - sidx, 1);

        // Random traffic with occasional overflow clears.
        for (int i = 0; i < 80; i++) begin
            wr   = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            clr  = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        wr = 0; clr = 0;
        wait_idle(3000);
        chk("drained", exp_q.size(), 0);

        // Default bit period: check first and last cycle of every bit.
        b_wr = 1'b1; b_data = 8'h41;
        n = cyc + 1;
        @(negedge clk);
        b_wr = 1'b0;
        for (int i = 0; i < 10 && b_line !== 1'b0; i++) @(negedge clk);
        chk("def_latency", cyc, n + 2);
        t0 = 0;
        for (int t = 0; t < 10 * DCPB; t++) begin
            if ((t % DCPB) == 0 || (t % DCPB) == DCPB - 1)
                chk("def_bit", b_line, def_bit(8'h41, t / DCPB));
            @(negedge clk);
        end
        chk("def_after", b_line, 1);
        repeat (3) @(negedge clk);
        chk("def_busy", b_busy, 0);
        chk("def_ovf",  b_ovf,  0);
        chk("def_empty_full", {b_empty, b_full}, 2'b10);

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mfp_uart_tx.md
Name: mfp_uart_tx

Overview:
- 8N1 UART transmitter. It is the transmit counterpart of the board-level UART_RX path.
- Memory-mapped GPIO logic in mfp_sys pushes bytes into a small FIFO. The block serialises them LSB-first onto a single UART_TX pin for the Nexys4 DDR USB-UART bridge.
- Runs entirely in the processor clock domain (clk_wiz_0 output).

Parameters:
- CLKS_PER_BIT, 434: SI_ClkIn cycles per bit (50 MHz / 115200). Legal range ≥ 2.
- FIFO_DEPTH, 16: transmit FIFO entries. Power of two, ≥ 2.

Ports:
- SI_ClkIn  input  1  system clock.
- SI_Reset_N  input  1  asynchronous, active-low reset.
- tx_wr  input  1  write strobe, one byte per cycle.
- tx_data  input  8  byte to enqueue; sampled when tx_wr=1.
- tx_full  output  1  FIFO holds FIFO_DEPTH entries.
- tx_empty  output  1  FIFO holds 0 entries.
- tx_busy  output  1  FIFO non-empty or a frame is in progress.
- tx_ovf  output  1  sticky: a write was dropped because the FIFO was full.
- tx_ovf_clr  input  1  clears tx_ovf.
- UART_TX  output  1  serial line, idle high.

Behaviour:
- Reset (asynchronous, active-low; takes effect mid-frame too):
  - UART_TX=1, tx_busy=0, tx_full=0, tx_empty=1, tx_ovf=0.
  - FIFO pointers and count cleared; FSM in IDLE; baud counter 0.
  - A frame in progress is abandoned immediately; no partial bits resume after release.
- FIFO:
  - Synchronous write. Count has width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - tx_wr while tx_full=1: byte dropped, tx_ovf set next edge. This holds even if the FSM pops in the same cycle (full is evaluated on the pre-edge count).
  - Write and pop in the same cycle (not full): count unchanged, both take effect.
  - tx_ovf_clr and an overflowing write in the same cycle: set wins.
  - tx_full, tx_empty and tx_ovf are registered, derived from the count.
- FSM states:
  - IDLE: UART_TX=1. If FIFO non-empty, pop the head into the shift register and go to START with baud counter=0.
  - START: UART_TX=0 for CLKS_PER_BIT cycles, then DATA, bit index 0.
  - DATA: UART_TX = shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7, go to STOP.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles. Then, if FIFO non-empty, pop and go directly to START (no idle gap between back-to-back frames); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state and advances the bit on the terminal count. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame lasts exactly 10*CLKS_PER_BIT cycles.
- Latency: with the FIFO empty and the FSM idle, a tx_wr at edge N gives tx_empty=0 at N+1, and UART_TX falls at edge N+2 (pop at N+1, start bit registered at N+2).
- UART_TX is driven from a flop (glitch-free). tx_busy = !tx_empty || state!=IDLE, registered.
- tx_data is ignored when tx_wr=0. Writes are accepted in every FSM state.

Decomposition:
- Shared package/header (mfp_uart_const.vh): the UART_STATE_IDLE/START/DATA/STOP encodings (2-bit), the default CLKS_PER_BIT, and the data width 8. The future receiver uses the same header.
- One sub-module: mfp_uart_tx_fifo (parameterised synchronous FIFO with count, full, empty and pop).
- The top level keeps the FSM, baud counter, shift register and overflow flag.
- Expected size ≈ 200 lines total.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated):
- Single byte: write 0xA5 at edge N while idle -> UART_TX low at N+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles. tx_busy returns to 0 after the stop bit. Total frame 40 cycles.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous 40-cycle frames with no idle cycles between stop and next start. tx_empty=1 after the third pop.
- Overflow: while the first frame is sending, write 6 bytes -> 4 queued plus the in-flight byte. Exactly one write is dropped and tx_ovf=1. Pulse tx_ovf_clr -> tx_ovf=0 next cycle. Only the accepted bytes appear on the line, in order.
- Full boundary: with the FIFO full, tx_wr in the same cycle as a STOP→START pop -> write rejected, tx_ovf=1, count drops to DEPTH-1.
- Reset mid-frame: assert SI_Reset_N=0 during DATA bit 3 -> UART_TX=1 without waiting for a clock edge, all flags at reset values. After release, no output until the next write. A new write of 0x3C then sends a clean frame.
- Default parameters (CLKS_PER_BIT=434): one frame of 0x41 -> each bit is exactly 434 cycles, frame 4340 cycles.
